// File: rtl/poco_mem_io.sv
// Memory and I/O subsystem behind the poco CPU memory port: word RAM with
// combinational read plus an I/O window with output/input FIFOs, status and a cycle counter.
module poco_mem_io #(
  parameter int                 DATA_W  = 16,
  parameter int                 MEM_AW  = 12,
  parameter int                 FIFO_AW = 3,
  parameter logic [DATA_W-1:0]  IO_BASE = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [DATA_W:0]  RAM_WORDS = (DATA_W+1)'(1 << MEM_AW);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW+1)'(DEPTH);

  logic [DATA_W-1:0]  mem_q     [2**MEM_AW];
  logic [DATA_W-1:0]  out_mem_q [DEPTH];
  logic [DATA_W-1:0]  in_mem_q  [DEPTH];

  logic [FIFO_AW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic [FIFO_AW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [FIFO_AW:0]   out_cnt_q, out_cnt_d, in_cnt_q, in_cnt_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  logic [DATA_W-1:0]  cyc_q, cyc_d;

  logic              is_ram, is_io;
  logic [DATA_W-1:0] io_off;
  logic              wr_out, wr_in, wr_stat, wr_cyc;
  logic              out_empty, out_full, in_empty, in_full;
  logic              out_pop, out_push, in_push, in_pop, ovf_set, unf_set;
  logic [DATA_W-1:0] in_head, status;

  assign is_ram  = {1'b0, cpu_addr} < RAM_WORDS;
  assign is_io   = cpu_addr >= IO_BASE;
  assign io_off  = cpu_addr - IO_BASE;
  assign wr_out  = cpu_we & is_io & (io_off == DATA_W'(0));
  assign wr_in   = cpu_we & is_io & (io_off == DATA_W'(1));
  assign wr_stat = cpu_we & is_io & (io_off == DATA_W'(2));
  assign wr_cyc  = cpu_we & is_io & (io_off == DATA_W'(3));

  assign out_empty = (out_cnt_q == '0);
  assign out_full  = (out_cnt_q == FULL_CNT);
  assign in_empty  = (in_cnt_q == '0);
  assign in_full   = (in_cnt_q == FULL_CNT);

  // A host pop frees the slot the CPU push lands in, so full+pop+push is not an overflow
  assign out_pop  = ~out_empty & out_ready;
  assign out_push = wr_out & (~out_full | out_pop);
  assign ovf_set  = wr_out & out_full & ~out_pop;
  assign in_push  = in_valid & ~in_full;
  assign in_pop   = wr_in & ~in_empty;
  assign unf_set  = wr_in & in_empty;

  assign out_valid = ~out_empty;
  assign out_data  = out_empty ? '0 : out_mem_q[out_rp_q];
  assign in_ready  = ~in_full;
  assign in_head   = in_empty ? '0 : in_mem_q[in_rp_q];
  assign status    = {4'(in_cnt_q), 4'(out_cnt_q), 2'b00, unf_q, ovf_q,
                      in_full, in_empty, out_empty, out_full};

  always_comb begin
    cpu_rdata = '0;
    if (is_ram) begin
      cpu_rdata = mem_q[cpu_addr[MEM_AW-1:0]];
    end else if (is_io) begin
      case (io_off)
        DATA_W'(1): cpu_rdata = in_head;
        DATA_W'(2): cpu_rdata = status;
        DATA_W'(3): cpu_rdata = cyc_q;
        default:    cpu_rdata = '0;
      endcase
    end
  end

  always_comb begin
    out_wp_d  = out_push ? out_wp_q + 1'b1 : out_wp_q;
    out_rp_d  = out_pop  ? out_rp_q + 1'b1 : out_rp_q;
    out_cnt_d = out_cnt_q;
    if (out_push && !out_pop)      out_cnt_d = out_cnt_q + 1'b1;
    else if (!out_push && out_pop) out_cnt_d = out_cnt_q - 1'b1;

    in_wp_d  = in_push ? in_wp_q + 1'b1 : in_wp_q;
    in_rp_d  = in_pop  ? in_rp_q + 1'b1 : in_rp_q;
    in_cnt_d = in_cnt_q;
    if (in_push && !in_pop)      in_cnt_d = in_cnt_q + 1'b1;
    else if (!in_push && in_pop) in_cnt_d = in_cnt_q - 1'b1;

    ovf_d = ovf_set | (ovf_q & ~(wr_stat & cpu_wdata[4]));
    unf_d = unf_set | (unf_q & ~(wr_stat & cpu_wdata[5]));
    // A write zeroes the counter for the current cycle, so it reads 1 afterwards
    cyc_d = wr_cyc ? DATA_W'(1) : cyc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_cnt_q <= '0;
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      in_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      cyc_q     <= '0;
    end else begin
      out_wp_q  <= out_wp_d;
      out_rp_q  <= out_rp_d;
      out_cnt_q <= out_cnt_d;
      in_wp_q   <= in_wp_d;
      in_rp_q   <= in_rp_d;
      in_cnt_q  <= in_cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      cyc_q     <= cyc_d;
    end
  end

  // Storage arrays carry no reset; emptiness is tracked by the counts alone
  always_ff @(posedge clk) begin
    if (cpu_we && is_ram) mem_q[cpu_addr[MEM_AW-1:0]] <= cpu_wdata;
    if (out_push)         out_mem_q[out_wp_q]          <= cpu_wdata;
    if (in_push)          in_mem_q[in_wp_q]            <= in_data;
  end

endmodule

// File: tb/tb_poco_mem_io.sv
// Bench for poco_mem_io: queue-based reference model, output-FIFO scoreboard with a
// separate negedge monitor, directed scenarios followed by randomized traffic.
module tb_poco_mem_io;

  logic        clk, rst_n;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, out_data, in_data;
  logic        cpu_we, out_valid, out_ready, in_valid, in_ready;

  poco_mem_io dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [15:0] m_ram [4096];
  logic [15:0] m_out [$];
  logic [15:0] m_in  [$];
  logic [15:0] exp_q [$];
  bit          m_ovf, m_unf;
  logic [15:0] m_cyc;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    return {4'(m_in.size()), 4'(m_out.size()), 2'b00, m_unf, m_ovf,
            m_in.size() == 8, m_in.size() == 0, m_out.size() == 0, m_out.size() == 8};
  endfunction

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    if (a < 16'h1000) return m_ram[a[11:0]];
    if (a >= 16'hFF00) begin
      case (a - 16'hFF00)
        16'd1:   return (m_in.size() != 0) ? m_in[0] : 16'h0000;
        16'd2:   return m_status();
        16'd3:   return m_cyc;
        default: return 16'h0000;
      endcase
    end
    return 16'h0000;
  endfunction

  // Apply one clock of the spec's rules to the model using the current inputs
  task automatic model_step();
    bit hpop, hpush;
    bit ovf_set = 0, unf_set = 0, ovf_clr = 0, unf_clr = 0, cyc_wr = 0;
    hpop  = (m_out.size() != 0) && out_ready;
    hpush = in_valid && (m_in.size() < 8);
    if (hpop) void'(m_out.pop_front());
    if (cpu_we) begin
      if (cpu_addr < 16'h1000) m_ram[cpu_addr[11:0]] = cpu_wdata;
      else if (cpu_addr >= 16'hFF00) begin
        case (cpu_addr - 16'hFF00)
          16'd0: if (m_out.size() < 8) begin
                   m_out.push_back(cpu_wdata);
                   exp_q.push_back(cpu_wdata);
                 end else ovf_set = 1;
          16'd1: if (m_in.size() == 0) unf_set = 1;
                 else void'(m_in.pop_front());
          16'd2: begin ovf_clr = cpu_wdata[4]; unf_clr = cpu_wdata[5]; end
          16'd3: cyc_wr = 1;
          default: ;
        endcase
      end
    end
    if (hpush) m_in.push_back(in_data);
    m_ovf = ovf_set | (m_ovf & !ovf_clr);
    m_unf = unf_set | (m_unf & !unf_clr);
    m_cyc = cyc_wr ? 16'h0001 : m_cyc + 16'h0001;
  endtask

  task automatic model_reset();
    m_out.delete(); m_in.delete(); exp_q.delete();
    m_ovf = 0; m_unf = 0; m_cyc = 16'h0000;
  endtask

  task automatic tick();
    #1;
    chk("rdata", cpu_rdata, exp_rd(cpu_addr));
    chk("out_valid", {15'd0, out_valid}, {15'd0, m_out.size() != 0});
    chk("in_ready", {15'd0, in_ready}, {15'd0, m_in.size() < 8});
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_we = 0; cpu_addr = 16'h0100;
    repeat (n) tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1;
    tick();
    cpu_we = 0;
  endtask

  task automatic peek(input string name, input logic [15:0] a, input logic [15:0] exp);
    cpu_addr = a; cpu_we = 0;
    #1;
    chk(name, cpu_rdata, exp);
    tick();
  endtask

  // Scoreboard monitor: every host handshake pops the next expected word
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL out_pop: got %h expected none queued at %0t", out_data, $time);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end else if (!out_valid) begin
        chk("out_data_idle", out_data, 16'h0000);
      end
    end
  end

  initial begin
    rst_n = 0; cpu_addr = 16'hFF02; cpu_wdata = 0; cpu_we = 0;
    out_ready = 0; in_data = 0; in_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // reset state
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_data", out_data, 16'h0000);
    peek("rst_status", 16'hFF02, 16'h0006);

    // RAM and hole
    wr(16'h0000, 16'h5A5A);
    for (int i = 0; i < 16; i++) wr(16'h0100 + 16'(i), 16'($urandom));
    wr(16'h0123, 16'hBEEF);
    peek("ram_beef", 16'h0123, 16'hBEEF);
    peek("hole_rd", 16'h2000, 16'h0000);
    wr(16'h2000, 16'h1111);
    peek("hole_wr_ram0", 16'h0000, 16'h5A5A);

    // output FIFO overflow and drain
    out_ready = 0;
    for (int i = 1; i <= 9; i++) wr(16'hFF00, 16'(i));
    peek("ovf_status", 16'hFF02, 16'h0815);
    out_ready = 1;
    idle(9);
    chk("drain_valid", {15'd0, out_valid}, 16'd0);
    chk("drain_sb_empty", 16'(exp_q.size()), 16'd0);
    wr(16'hFF02, 16'h0010);
    peek("ovf_clr", 16'hFF02, 16'h0006);

    // input FIFO and underflow
    in_valid = 1; in_data = 16'h00A1; idle(1);
    in_data = 16'h00A2; idle(1);
    in_valid = 0;
    peek("in_head_a1", 16'hFF01, 16'h00A1);
    wr(16'hFF01, 16'h0000);
    peek("in_head_a2", 16'hFF01, 16'h00A2);
    wr(16'hFF01, 16'h0000);
    wr(16'hFF01, 16'h0000);
    peek("unf_status", 16'hFF02, 16'h0026);
    wr(16'hFF02, 16'h0020);

    // push into full FIFO with simultaneous host pop
    out_ready = 0;
    for (int i = 0; i < 8; i++) wr(16'hFF00, 16'h0100 + 16'(i));
    out_ready = 1;
    wr(16'hFF00, 16'h7777);
    out_ready = 0;
    peek("full_pushpop", 16'hFF02, 16'h0805);
    out_ready = 1;
    idle(9);
    chk("pushpop_sb_empty", 16'(exp_q.size()), 16'd0);

    // cycle counter load and wrap
    wr(16'hFF03, 16'h1234);
    idle(4);
    peek("cyc_5", 16'hFF03, 16'd5);
    idle(65529);
    peek("cyc_ffff", 16'hFF03, 16'hFFFF);
    peek("cyc_wrap", 16'hFF03, 16'h0000);

    // reset mid-stream
    out_ready = 0;
    in_valid = 1; in_data = 16'h0C0C;
    for (int i = 0; i < 3; i++) wr(16'hFF00, 16'h0300 + 16'(i));
    in_valid = 0;
    cpu_addr = 16'hFF02;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    chk("mid_rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("mid_rst_status", cpu_rdata, 16'h0006);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    peek("rst_ram_kept", 16'h0123, 16'hBEEF);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2)      cpu_addr = 16'h0100 + 16'($urandom_range(0, 15));
      else if (r == 3) cpu_addr = 16'(16'h1000 + $urandom_range(0, 16'hEEFF));
      else             cpu_addr = 16'hFF00 + 16'($urandom_range(0, 5));
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_wdata = 16'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = 16'($urandom);
      tick();
    end
    in_valid = 0; out_ready = 1;
    idle(10);
    chk("final_sb_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
